barrel_rotator_pipe: RTL

BARREL_ROTATOR_PIPE -- requirements
Module: barrel_rotator_pipe

---
 rtl/barrel_rotator_pkg.sv | 20 ++
 rtl/barrel_rotator_stage.sv | 80 ++++++++
 rtl/barrel_rotator_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/barrel_rotator_pkg.sv
// Shared types for the pipelined barrel rotator: operation codes and the per-stage control payload.
// The carry field exists only when BARREL_ROTATOR_STATUS_EN is defined.
package barrel_rotator_pkg;

  typedef enum logic [1:0] {
    ROL = 2'd0,
    ROR = 2'd1,
    SHL = 2'd2,
    SAR = 2'd3
  } op_t;

  typedef struct packed {
    logic valid;
    op_t  op;
`ifdef BARREL_ROTATOR_STATUS_EN
    logic carry;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/barrel_rotator_stage.sv
// One pipeline stage: conditionally shifts/rotates by 2^I and registers the result.
// BARREL_ROTATOR_STATUS_EN adds tracking of the last bit moved out.
module barrel_rotator_stage
  import barrel_rotator_pkg::*;
#(
  parameter int N = 8,
  parameter int I = 0,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_valid,
  input  logic [1:0]   up_op,
  input  logic [N-1:0] up_data,
  input  logic [S-1:0] up_amt,
`ifdef BARREL_ROTATOR_STATUS_EN
  input  logic         up_carry,
  output logic         dn_carry,
`endif
  output logic         dn_valid,
  output logic [1:0]   dn_op,
  output logic [N-1:0] dn_data,
  output logic [S-1:0] dn_amt
);

  localparam int SH = 1 << I;

  stage_ctl_t   ctl_q;
  logic [N-1:0] data_q;
  logic [S-1:0] amt_q;
  logic [N-1:0] shifted;

  // The amount arrives pre-shifted, so bit 0 always belongs to this stage.
  always_comb begin
    shifted = up_data;
    if (up_amt[0]) begin
      unique case (op_t'(up_op))
        ROL: shifted = (up_data << SH) | (up_data >> (N - SH));
        ROR: shifted = (up_data >> SH) | (up_data << (N - SH));
        SHL: shifted = up_data << SH;
        SAR: shifted = $signed(up_data) >>> SH;
      endcase
    end
  end

`ifdef BARREL_ROTATOR_STATUS_EN
  logic moved;

  always_comb begin
    moved = up_data[SH-1];
    if (up_op == ROL || up_op == SHL) moved = up_data[N-SH];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q  <= '0;
      data_q <= '0;
      amt_q  <= '0;
    end else if (en) begin
      ctl_q.valid <= up_valid;
      ctl_q.op    <= op_t'(up_op);
`ifdef BARREL_ROTATOR_STATUS_EN
      ctl_q.carry <= up_amt[0] ? moved : up_carry;
`endif
      data_q      <= shifted;
      amt_q       <= up_amt >> 1;
    end
  end

  assign dn_valid = ctl_q.valid;
  assign dn_op    = ctl_q.op;
  assign dn_data  = data_q;
  assign dn_amt   = amt_q;
`ifdef BARREL_ROTATOR_STATUS_EN
  assign dn_carry = ctl_q.carry;
`endif

endmodule

// File: rtl/barrel_rotator_pipe.sv
// Pipelined barrel rotator/shifter (ROL, ROR, SHL, SAR) with valid/ready flow control.
// Define BARREL_ROTATOR_STATUS_EN to add the out_zero and out_carry status outputs.
module barrel_rotator_pipe
  import barrel_rotator_pkg::*;
#(
  parameter int N = 8,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_amt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef BARREL_ROTATOR_STATUS_EN
  output logic         out_zero,
  output logic         out_carry,
`endif
  output logic [N-1:0] out_data
);

  logic         en;
  logic         cap_valid;
  logic [1:0]   cap_op;
  logic [N-1:0] cap_data;
  logic [S-1:0] cap_amt;

  logic         valid_p [0:S];
  logic [1:0]   op_p    [0:S];
  logic [N-1:0] data_p  [0:S];
  logic [S-1:0] amt_p   [0:S];
`ifdef BARREL_ROTATOR_STATUS_EN
  logic         carry_p [0:S];
`endif

  // One global enable: the whole pipe freezes while a result waits for its consumer.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // The operand is captured unshifted, so a result appears S advances after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_op    <= '0;
      cap_data  <= '0;
      cap_amt   <= '0;
    end else if (en) begin
      cap_valid <= in_valid;
      cap_op    <= in_op;
      cap_data  <= in_data;
      cap_amt   <= in_amt;
    end
  end

  assign valid_p[0] = cap_valid;
  assign op_p[0]    = cap_op;
  assign data_p[0]  = cap_data;
  assign amt_p[0]   = cap_amt;
`ifdef BARREL_ROTATOR_STATUS_EN
  assign carry_p[0] = 1'b0;
`endif

  for (genvar i = 0; i < S; i++) begin : g_stage
    barrel_rotator_stage #(
      .N(N),
      .I(i)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up_valid(valid_p[i]),
      .up_op   (op_p[i]),
      .up_data (data_p[i]),
      .up_amt  (amt_p[i]),
`ifdef BARREL_ROTATOR_STATUS_EN
      .up_carry(carry_p[i]),
      .dn_carry(carry_p[i+1]),
`endif
      .dn_valid(valid_p[i+1]),
      .dn_op   (op_p[i+1]),
      .dn_data (data_p[i+1]),
      .dn_amt  (amt_p[i+1])
    );
  end

  assign out_valid = valid_p[S];
  assign out_data  = data_p[S];
`ifdef BARREL_ROTATOR_STATUS_EN
  assign out_zero  = out_valid && (out_data == '0);
  assign out_carry = carry_p[S];
`endif

endmodule
